timer_entry: RTL

Keypad entry stage of the microwave timer, directly upstream of the seconds/tens/minutes down-counters. It accepts one decimal key at a time, shifts the digits into a three-digit BCD time value (M:SS), and validates it on ENTER. It then presents the value on parallel data buses with an active-low load strobe that the counters sample on their clock edge. Invalid entries (seconds-tens > 5) are rejected with an error pulse; the counters are left untouched.

---
 rtl/timer_entry.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/timer_entry.sv
// timer_entry: keypad entry stage for the microwave timer.
// Shifts decimal keys into a three-digit BCD value (M:SS), validates it on
// ENTER and drives an active-low load strobe to the downstream counters.
// Entries whose seconds-tens digit exceeds 5 are rejected with an err pulse.

module timer_entry #(
  parameter int unsigned LOAD_PULSE = 1  // loadn low cycles per accepted ENTER (1..15)
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [3:0] key,
  input  logic       key_valid,
  input  logic       busy,
  output logic [3:0] min_data,
  output logic [3:0] tens_data,
  output logic [3:0] ones_data,
  output logic       loadn,
  output logic       err,
  output logic [1:0] ndigits
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ENTRY = 2'd1,
    ST_LOAD  = 2'd2
  } state_e;

  localparam logic [3:0] KEY_CLEAR  = 4'd10;
  localparam logic [3:0] KEY_ENTER  = 4'd11;
  localparam logic [3:0] MAX_TENS   = 4'd5;
  // Remaining-cycle counter starts at LOAD_PULSE-1 so the exit edge is the
  // LOAD_PULSE-th edge after ENTER.
  localparam logic [3:0] PULSE_LAST = 4'(LOAD_PULSE - 1);

  state_e     state_q, state_d;
  logic [3:0] min_q, min_d;
  logic [3:0] tens_q, tens_d;
  logic [3:0] ones_q, ones_d;
  logic [1:0] ndigits_q, ndigits_d;
  logic       loadn_q, loadn_d;
  logic       err_q, err_d;
  logic [3:0] cnt_q, cnt_d;

  logic       is_digit_s;
  logic       room_s;

  assign is_digit_s = (key <= 4'd9);
  assign room_s     = (ndigits_q != 2'd3);

  // Next-state and next-output decode for the entry/load sequencer.
  always_comb begin
    state_d   = state_q;
    min_d     = min_q;
    tens_d    = tens_q;
    ones_d    = ones_q;
    ndigits_d = ndigits_q;
    loadn_d   = loadn_q;
    err_d     = 1'b0;
    cnt_d     = cnt_q;

    case (state_q)
      ST_IDLE, ST_ENTRY: begin
        if (key_valid) begin
          if (is_digit_s) begin
            // Digits are dropped while the timer runs or once three are held.
            if (!busy && room_s) begin
              min_d     = tens_q;
              tens_d    = ones_q;
              ones_d    = key;
              ndigits_d = ndigits_q + 2'd1;
              state_d   = ST_ENTRY;
            end else begin
              state_d = state_q;
            end
          end else if (key == KEY_CLEAR) begin
            // CLEAR is honoured even while busy.
            min_d     = 4'd0;
            tens_d    = 4'd0;
            ones_d    = 4'd0;
            ndigits_d = 2'd0;
            state_d   = ST_IDLE;
          end else if (key == KEY_ENTER) begin
            // ENTER with nothing entered never loads a zero time.
            if ((state_q == ST_ENTRY) && !busy) begin
              if (tens_q <= MAX_TENS) begin
                state_d = ST_LOAD;
                loadn_d = 1'b0;
                cnt_d   = PULSE_LAST;
              end else begin
                err_d = 1'b1;
              end
            end else begin
              state_d = state_q;
            end
          end else begin
            // Codes 12..15 carry no function.
            state_d = state_q;
          end
        end else begin
          state_d = state_q;
        end
      end

      ST_LOAD: begin
        // Keys are ignored; digits stay on the buses until the strobe ends.
        if (cnt_q == 4'd0) begin
          state_d   = ST_IDLE;
          loadn_d   = 1'b1;
          min_d     = 4'd0;
          tens_d    = 4'd0;
          ones_d    = 4'd0;
          ndigits_d = 2'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        loadn_d   = 1'b1;
        min_d     = 4'd0;
        tens_d    = 4'd0;
        ones_d    = 4'd0;
        ndigits_d = 2'd0;
        cnt_d     = 4'd0;
      end
    endcase
  end

  // State and output registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= ST_IDLE;
      min_q     <= 4'd0;
      tens_q    <= 4'd0;
      ones_q    <= 4'd0;
      ndigits_q <= 2'd0;
      loadn_q   <= 1'b1;
      err_q     <= 1'b0;
      cnt_q     <= 4'd0;
    end else begin
      state_q   <= state_d;
      min_q     <= min_d;
      tens_q    <= tens_d;
      ones_q    <= ones_d;
      ndigits_q <= ndigits_d;
      loadn_q   <= loadn_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign min_data  = min_q;
  assign tens_data = tens_q;
  assign ones_data = ones_q;
  assign ndigits   = ndigits_q;
  assign loadn     = loadn_q;
  assign err       = err_q;

endmodule
